// File: rtl/copro_issuer_if.sv
// Request/response and instruction-port signals between the host bridge,
// the issuer and the matrix coprocessor.
interface copro_issuer_if;
    logic         start;
    logic [3:0]   op;
    logic [15:0]  scalar;
    logic [199:0] mat_a;
    logic [199:0] mat_b;
    logic [15:0]  data_read;
    logic [31:0]  instruction;
    logic         activate_instruction;
    logic         busy;
    logic         done;
    logic         error;
    logic [199:0] result;

    modport master (
        input  start, op, scalar, mat_a, mat_b, data_read,
        output instruction, activate_instruction, busy, done, error, result
    );

    modport slave (
        output start, op, scalar, mat_a, mat_b, data_read,
        input  instruction, activate_instruction, busy, done, error, result
    );
endinterface

// File: rtl/copro_issuer.sv
// Runs one matrix transaction on the coprocessor instruction port:
// write A and B, issue the arithmetic op, then read C back.
module copro_issuer #(
    parameter int MEM_WAIT = 8,
    parameter int OP_WAIT  = 64
) (
    input  logic           clk,
    input  logic           reset,
    copro_issuer_if.master bus
);
    localparam int CNT_MAX = (MEM_WAIT > OP_WAIT) ? MEM_WAIT : OP_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] OPC_WRITE = 4'h1;
    localparam logic [3:0] OPC_READ  = 4'h2;
    localparam logic [3:0] OPC_FIRST = 4'h3;
    localparam logic [3:0] OPC_LAST  = 4'hC;
    localparam logic [3:0] LAST_WORD = 4'd12;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_READBACK, S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_wait;
    logic [3:0]         r_idx;
    logic [3:0]         r_op;
    logic [15:0]        r_scalar;
    logic [199:0]       r_mat_a;
    logic [199:0]       r_mat_b;
    logic [199:0]       r_result;
    logic               r_error;

    logic               w_op_valid;
    logic [CNT_W-1:0]   w_wait_last;
    logic               w_wait_end;
    logic               w_last_word;
    logic [15:0]        w_a_word;
    logic [15:0]        w_b_word;

    assign w_op_valid  = (bus.op >= OPC_FIRST) && (bus.op <= OPC_LAST);
    assign w_wait_last = (r_state == S_EXEC) ? CNT_W'(OP_WAIT) : CNT_W'(MEM_WAIT);
    assign w_wait_end  = (r_wait == w_wait_last);
    assign w_last_word = (r_idx == LAST_WORD);

    // Word 12 carries only element 24; its upper byte is zero on the wire.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_a_word = '0;
        w_b_word = '0;
        for (int k = 0; k < 12; k++) begin
            if (r_idx == 4'(k)) begin
                w_a_word = r_mat_a[16*k +: 16];
                w_b_word = r_mat_b[16*k +: 16];
            end
        end
        if (r_idx == LAST_WORD) begin
            w_a_word = {8'h00, r_mat_a[199:192]};
            w_b_word = {8'h00, r_mat_b[199:192]};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (bus.start) w_next = w_op_valid ? S_LOAD_A : S_DONE;
            S_LOAD_A:   if (w_wait_end && w_last_word) w_next = S_LOAD_B;
            S_LOAD_B:   if (w_wait_end && w_last_word) w_next = S_EXEC;
            S_EXEC:     if (w_wait_end) w_next = S_READBACK;
            S_READBACK: if (w_wait_end && w_last_word) w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Wait counter reloads per instruction; the word index steps when a window closes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait   <= '0;
            r_idx    <= '0;
            r_op     <= '0;
            r_scalar <= '0;
            r_mat_a  <= '0;
            r_mat_b  <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wait <= '0;
                    r_idx  <= '0;
                    if (bus.start) begin
                        r_op     <= bus.op;
                        r_scalar <= bus.scalar;
                        r_mat_a  <= bus.mat_a;
                        r_mat_b  <= bus.mat_b;
                        r_error  <= !w_op_valid;
                    end
                end
                S_LOAD_A, S_LOAD_B, S_EXEC, S_READBACK: begin
                    if ((r_state == S_READBACK) && w_wait_end) begin
                        for (int k = 0; k < 12; k++) begin
                            if (r_idx == 4'(k)) r_result[16*k +: 16] <= bus.data_read;
                        end
                        if (r_idx == LAST_WORD) r_result[199:192] <= bus.data_read[7:0];
                    end
                    if (w_wait_end) begin
                        r_wait <= '0;
                        r_idx  <= (w_last_word || (r_state == S_EXEC)) ? 4'd0 : r_idx + 4'd1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: begin
                    r_wait <= '0;
                    r_idx  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.instruction = '0;
        bus.busy        = 1'b1;
        bus.done        = 1'b0;
        bus.error       = 1'b0;
        case (r_state)
            S_IDLE:     bus.busy = 1'b0;
            S_LOAD_A:   bus.instruction = {4'h0, w_a_word, {4'h0, r_idx}, OPC_WRITE};
            S_LOAD_B:   bus.instruction = {4'h0, w_b_word, {4'h1, r_idx}, OPC_WRITE};
            S_EXEC:     bus.instruction = {4'h0, r_scalar, 8'h00, r_op};
            S_READBACK: bus.instruction = {4'h0, 16'h0000, {4'h2, r_idx}, OPC_READ};
            S_DONE: begin
                bus.done  = 1'b1;
                bus.error = r_error;
            end
            default: bus.busy = 1'b0;
        endcase
        bus.activate_instruction = (r_state inside {S_LOAD_A, S_LOAD_B, S_EXEC, S_READBACK})
                                   && (r_wait == '0);
    end

    assign bus.result = r_result;
endmodule

// File: doc/copro_issuer.md
# copro_issuer

Host-side initiator for the matrix coprocessor's 32-bit instruction port. It takes one matrix request (opcode, up to two 5x5 int8 operands, scalar) and runs the whole transaction against the coprocessor. It writes A and B into coprocessor memory with WRITE instructions, issues the arithmetic opcode, then reads the result matrix back with READ instructions. It sits between the HPS/bus bridge and the coprocessor top, driving `instruction`/`activate_instruction` and sampling `data_read`.

## Interface
- MEM_WAIT, 8: idle cycles after each WRITE/READ pulse before the next pulse or data sample.
- OP_WAIT, 64: idle cycles after the arithmetic-op pulse before readback starts. Must cover the coprocessor's load+execute+writeback.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request strobe, sampled only in IDLE.
- op  in  4  arithmetic opcode, 4'b0011..4'b1100 (SUM..DET5).
- scalar  in  16  data field of the op instruction (MULSCL scalar, else ignored by coprocessor).
- mat_a  in  200  matrix A, element i (row-major, 0..24) at bits [8i+7:8i].
- mat_b  in  200  matrix B, same packing.
- data_read  in  16  coprocessor read data.
- instruction  out  32  {4'b0, data[15:0], address[7:0], opcode[3:0]}.
- activate_instruction  out  1  one-cycle issue pulse.
- busy  out  1  high from the cycle after an accepted start through the cycle done is high.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with done; 1 = op rejected.
- result  out  200  matrix C, same packing, valid from done until the next accepted start.

## Operation
- Word packing: word k (0..12) = matrix bits [16k+15:16k]. Word 12 = {8'h00, bits[199:192]}. Readback unpacks the same way; the upper byte of word 12 is discarded.
- Address map: A words at 8'h00..8'h0C, B at 8'h10..8'h1C, C at 8'h20..8'h2C.
- States:
  - IDLE: on start, latch op/scalar/mat_a/mat_b.
    - If op is outside 3..12, go to DONE with error=1 and issue nothing.
    - Otherwise go to LOAD_A, word index=0.
  - LOAD_A: issue WRITE(1), address=index, data=A word. Wait MEM_WAIT. index 12 goes to LOAD_B with index 0, else index+1.
  - LOAD_B: same with address 8'h10+index, B words, then EXEC.
  - EXEC: issue {op, address 0, data=scalar}. Wait OP_WAIT, then go to READBACK with index 0.
  - READBACK: issue READ(1), address 8'h20+index. At the last wait cycle, capture data_read into word index of result. After index 12, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Each issue is one cycle with activate_instruction=1. `instruction` stays stable from the issue cycle through the end of its wait window. It is 0 in IDLE/DONE.
- start while busy is ignored; there is no queue.
- B is written even for single-operand ops (the coprocessor always loads both).

## Timing
- Reset values: instruction=0, activate_instruction=0, busy=0, done=0, error=0, result=0, state IDLE, counters 0.
- Per memory instruction: 1 issue cycle + MEM_WAIT wait cycles. Consecutive activate pulses are exactly MEM_WAIT+1 cycles apart.
- Latency (start sampled at edge 0):
  - First activate at cycle 1.
  - Op pulse at cycle 1 + 26·(MEM_WAIT+1).
  - done at cycle 39·(MEM_WAIT+1) + OP_WAIT + 2. Default: 417.
- Rejected op: done and error at cycle 1; busy is high only in that cycle.
- Readback sample: data_read is captured on the edge ending the last wait cycle, i.e. MEM_WAIT cycles after the READ pulse.
- Reset mid-transaction: the next cycle is IDLE with all outputs at reset values and no further pulses. Coprocessor state is not recovered; the host must re-issue.
- Counter wrap: the index wait counter is sized for max(MEM_WAIT, OP_WAIT). It reloads per instruction and never free-runs.

## Test plan
- Reset check: assert reset mid-LOAD_B (cycle 150) -> next cycle activate=0, busy=0, instruction=0; no pulses thereafter.
- Write sequence: mat_a element i = i, start with op=SUM.
  - First pulse: instruction=32'h00100_0_01 pattern, i.e. opcode 1, addr 0, data 16'h0100.
  - 13th pulse: addr 8'h0C, data 16'h0018.
  - Pulses are 9 cycles apart.
- Full SUM with a behavioural coprocessor model: A=B=all 1 -> result all 8'h02, done at cycle 417, error=0.
- MULSCL: scalar=3, A=all 2 -> op pulse carries {opcode 8, data 16'h0003}; result all 8'h06.
- Invalid op=4'b0001: done=1 and error=1 at cycle 1, zero activate pulses, result unchanged.
- start re-asserted at cycles 5 and 200 during a transaction -> ignored; exactly 40 activate pulses, one done.
